ibex_ascon_state_seq: RTL and testbench



---
 rtl/ibex_ascon_state_seq.sv | 134 +++++++++++++
 tb/tb_ibex_ascon_state_seq.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_ascon_state_seq.sv
// ASCON-p state holder and round sequencer for the EX-stage permutation datapath.
// Software accesses the 320-bit state as ten 32-bit words; a start command steps the rounds.
module ibex_ascon_state_seq #(
    parameter int unsigned  MaxRounds  = 12,
    parameter logic [319:0] ResetState = '0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         word_we_i,
    input  logic [3:0]   word_waddr_i,
    input  logic [31:0]  word_wdata_i,
    input  logic [3:0]   word_raddr_i,
    output logic [31:0]  word_rdata_o,
    input  logic         perm_start_i,
    input  logic [3:0]   perm_rounds_i,
    output logic         perm_busy_o,
    output logic         perm_done_o,
    output logic         err_o,
    output logic [319:0] state_o,
    output logic         ascon_en_o,
    output logic [3:0]   round_idx_o,
    input  logic [319:0] state_update_i,
    input  logic         update_done_i
);

    localparam int unsigned NumWords   = 10;
    localparam logic [3:0]  MaxRoundsW = 4'(MaxRounds);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } fsm_e;

    fsm_e         r_fsm;
    fsm_e         w_fsm_next;
    logic [319:0] r_state;
    logic [3:0]   r_remaining;
    logic [3:0]   r_round_idx;
    logic         r_err;

    logic         w_err;
    logic         w_word_wr;
    logic         w_start;
    logic         w_commit;
    logic         w_rounds_ok;
    logic         w_waddr_ok;
    logic [31:0]  w_word_rdata;

    assign w_rounds_ok = (perm_rounds_i != 4'd0) && (perm_rounds_i <= MaxRoundsW);
    assign w_waddr_ok  = (word_waddr_i < 4'(NumWords));

    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    always_comb begin
        w_fsm_next = r_fsm;
        w_err      = 1'b0;
        w_word_wr  = 1'b0;
        w_start    = 1'b0;
        w_commit   = 1'b0;
        case (r_fsm)
            ST_IDLE: begin
                if (word_we_i) begin
                    if (w_waddr_ok) w_word_wr = 1'b1;
                    else            w_err     = 1'b1;
                end
                if (perm_start_i) begin
                    if (w_rounds_ok) begin
                        w_start    = 1'b1;
                        w_fsm_next = ST_RUN;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (word_we_i || perm_start_i) w_err = 1'b1;
                if (update_done_i) begin
                    w_commit = 1'b1;
                    if (r_remaining == 4'd1) w_fsm_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (word_we_i || perm_start_i) w_err = 1'b1;
                w_fsm_next = ST_IDLE;
            end
            default: w_fsm_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_fsm       <= ST_IDLE;
            r_state     <= ResetState;
            r_remaining <= '0;
            r_round_idx <= '0;
            r_err       <= 1'b0;
        end else begin
            r_fsm <= w_fsm_next;
            r_err <= w_err;
            if (w_start) begin
                r_remaining <= perm_rounds_i;
                r_round_idx <= MaxRoundsW - perm_rounds_i;
            end else if (w_commit) begin
                r_remaining <= r_remaining - 4'd1;
                r_round_idx <= r_round_idx + 4'd1;
            end
            if (w_commit) begin
                r_state <= state_update_i;
            end else if (w_word_wr) begin
                for (int i = 0; i < NumWords; i++) begin
                    if (word_waddr_i == 4'(i)) r_state[32*i +: 32] <= word_wdata_i;
                end
            end
        end
    end

    always_comb begin
        w_word_rdata = '0;
        for (int i = 0; i < NumWords; i++) begin
            if (word_raddr_i == 4'(i)) w_word_rdata = r_state[32*i +: 32];
        end
    end

    // Round index is only meaningful while the EX datapath is enabled.
    assign word_rdata_o = w_word_rdata;
    assign state_o      = r_state;
    assign perm_busy_o  = (r_fsm == ST_RUN);
    assign ascon_en_o   = (r_fsm == ST_RUN);
    assign perm_done_o  = (r_fsm == ST_DONE);
    assign round_idx_o  = (r_fsm == ST_RUN) ? r_round_idx : 4'd0;
    assign err_o        = r_err;

endmodule

// File: tb/tb_ibex_ascon_state_seq.sv
// Scoreboard bench for ibex_ascon_state_seq: stimulus queues expected round indices,
// final states and error pulses; a negedge monitor pops and compares them.
module tb_ibex_ascon_state_seq;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         word_we_i;
    logic [3:0]   word_waddr_i;
    logic [31:0]  word_wdata_i;
    logic [3:0]   word_raddr_i;
    logic [31:0]  word_rdata_o;
    logic         perm_start_i;
    logic [3:0]   perm_rounds_i;
    logic         perm_busy_o;
    logic         perm_done_o;
    logic         err_o;
    logic [319:0] state_o;
    logic         ascon_en_o;
    logic [3:0]   round_idx_o;
    logic [319:0] state_update_i;
    logic         update_done_i;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;

    logic [3:0]   q_idx[$];
    logic [319:0] q_done[$];
    bit           q_err[$];
    logic [319:0] exp_state;

    always #5 clk_i = ~clk_i;

    ibex_ascon_state_seq dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .word_we_i      (word_we_i),
        .word_waddr_i   (word_waddr_i),
        .word_wdata_i   (word_wdata_i),
        .word_raddr_i   (word_raddr_i),
        .word_rdata_o   (word_rdata_o),
        .perm_start_i   (perm_start_i),
        .perm_rounds_i  (perm_rounds_i),
        .perm_busy_o    (perm_busy_o),
        .perm_done_o    (perm_done_o),
        .err_o          (err_o),
        .state_o        (state_o),
        .ascon_en_o     (ascon_en_o),
        .round_idx_o    (round_idx_o),
        .state_update_i (state_update_i),
        .update_done_i  (update_done_i)
    );

    task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else             n_pass++;
    endtask

    task automatic flag(input string name);
        n_checks++;
        $display("FAIL %s: unexpected DUT output with nothing queued", name);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input logic [3:0] addr, input logic [31:0] data);
        word_we_i    = 1'b1;
        word_waddr_i = addr;
        word_wdata_i = data;
        if (addr < 4'd10) exp_state[32*addr +: 32] = data;
        else              q_err.push_back(1'b1);
        tick();
        word_we_i = 1'b0;
    endtask

    // Monitor: compares DUT outputs against queued expectations.
    always @(negedge clk_i) begin
        if (rst_ni === 1'b1) begin
            if (ascon_en_o) begin
                if (q_idx.size() == 0)  flag("round_idx_spurious");
                else if (update_done_i) check("round_idx_commit", 320'(round_idx_o), 320'(q_idx.pop_front()));
                else                    check("round_idx_hold", 320'(round_idx_o), 320'(q_idx[0]));
            end
            if (perm_done_o) begin
                done_cnt++;
                if (q_done.size() == 0) flag("perm_done_spurious");
                else                    check("final_state", state_o, q_done.pop_front());
            end
            if (err_o) begin
                if (q_err.size() == 0) flag("err_spurious");
                else                   void'(q_err.pop_front());
            end
        end
    end

    // EX model: each round returns state_o + 1 after 'stall' idle cycles.
    task automatic run_perm(input int rounds, input int stall, input bit inject,
                            input bit start_in_done, input logic [3:0] first_idx);
        int d0;
        bit all_en;
        for (int k = 0; k < rounds; k++) q_idx.push_back(first_idx + 4'(k));
        q_done.push_back(exp_state + 320'(rounds));
        d0     = done_cnt;
        all_en = 1'b1;
        perm_start_i  = 1'b1;
        perm_rounds_i = 4'(rounds);
        tick();
        perm_start_i = 1'b0;
        if (inject) begin
            q_err.push_back(1'b1);
            word_we_i     = 1'b1;
            word_waddr_i  = 4'd0;
            word_wdata_i  = 32'hBAD0_BAD0;
            perm_start_i  = 1'b1;
            perm_rounds_i = 4'd2;
            all_en &= ascon_en_o;
            tick();
            word_we_i    = 1'b0;
            perm_start_i = 1'b0;
        end
        for (int r = 0; r < rounds; r++) begin
            for (int s = 0; s < stall; s++) begin
                all_en &= ascon_en_o;
                tick();
            end
            all_en &= ascon_en_o;
            update_done_i  = 1'b1;
            state_update_i = state_o + 320'd1;
            tick();
            update_done_i = 1'b0;
        end
        check("run_en_every_cycle", 320'(all_en), 320'd1);
        check("done_after_last_commit", 320'(perm_done_o), 320'd1);
        check("busy_low_in_done", 320'(perm_busy_o), 320'd0);
        check("en_low_in_done", 320'(ascon_en_o), 320'd0);
        if (start_in_done) begin
            q_err.push_back(1'b1);
            perm_start_i  = 1'b1;
            perm_rounds_i = 4'd3;
        end
        tick();
        perm_start_i = 1'b0;
        check("idle_after_done", 320'(perm_busy_o), 320'd0);
        tick();
        check("done_exactly_once", 320'(done_cnt - d0), 320'd1);
        exp_state = exp_state + 320'(rounds);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni         = 1'b0;
        word_we_i      = 1'b0;
        word_waddr_i   = '0;
        word_wdata_i   = '0;
        word_raddr_i   = '0;
        perm_start_i   = 1'b0;
        perm_rounds_i  = '0;
        state_update_i = '0;
        update_done_i  = 1'b0;
        exp_state      = '0;
        tick();
        tick();
        rst_ni = 1'b1;
        tick();

        check("reset_busy", 320'(perm_busy_o), 320'd0);
        check("reset_en", 320'(ascon_en_o), 320'd0);
        check("reset_err", 320'(err_o), 320'd0);
        check("reset_idx", 320'(round_idx_o), 320'd0);
        for (int i = 0; i < 10; i++) begin
            word_raddr_i = 4'(i);
            #1;
            check($sformatf("reset_word%0d", i), 320'(word_rdata_o), 320'd0);
        end

        for (int i = 0; i < 10; i++) wr(4'(i), 32'h1000_0000 + 32'(i));
        for (int i = 0; i < 10; i++) begin
            word_raddr_i = 4'(i);
            #1;
            check($sformatf("readback_word%0d", i), 320'(word_rdata_o), 320'(32'h1000_0000 + 32'(i)));
        end
        word_raddr_i = 4'd12;
        #1;
        check("read_addr12", 320'(word_rdata_o), 320'd0);
        wr(4'd11, 32'hDEAD_BEEF);
        tick();
        check("bad_waddr_state", state_o, exp_state);

        // Completion strobe outside RUN must not touch the state.
        state_update_i = '1;
        update_done_i  = 1'b1;
        tick();
        update_done_i = 1'b0;
        check("update_outside_run", state_o, exp_state);

        run_perm(12, 0, 1'b0, 1'b0, 4'd0);
        run_perm(6, 3, 1'b0, 1'b1, 4'd6);
        run_perm(4, 0, 1'b1, 1'b0, 4'd8);

        q_err.push_back(1'b1);
        perm_start_i  = 1'b1;
        perm_rounds_i = 4'd0;
        tick();
        check("rounds0_no_run", 320'(perm_busy_o), 320'd0);
        q_err.push_back(1'b1);
        perm_rounds_i = 4'd13;
        tick();
        perm_start_i = 1'b0;
        check("rounds13_no_run", 320'(ascon_en_o), 320'd0);
        tick();
        check("bad_start_state", state_o, exp_state);

        // Write and start together: the single round must see the written word.
        exp_state[64 +: 32] = 32'hCAFE_0000;
        q_idx.push_back(4'd11);
        q_done.push_back(exp_state + 320'd1);
        word_we_i     = 1'b1;
        word_waddr_i  = 4'd2;
        word_wdata_i  = 32'hCAFE_0000;
        perm_start_i  = 1'b1;
        perm_rounds_i = 4'd1;
        tick();
        word_we_i      = 1'b0;
        perm_start_i   = 1'b0;
        update_done_i  = 1'b1;
        state_update_i = state_o + 320'd1;
        tick();
        update_done_i = 1'b0;
        check("wr_start_done", 320'(perm_done_o), 320'd1);
        tick();
        exp_state = exp_state + 320'd1;

        // Reset during round 5 of 12.
        for (int k = 0; k < 5; k++) q_idx.push_back(4'(k));
        perm_start_i  = 1'b1;
        perm_rounds_i = 4'd12;
        tick();
        perm_start_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            update_done_i  = 1'b1;
            state_update_i = state_o + 320'd1;
            tick();
        end
        update_done_i = 1'b0;
        check("midrun_idx5", 320'(round_idx_o), 320'd5);
        rst_ni = 1'b0;
        tick();
        check("midrst_state", state_o, 320'd0);
        check("midrst_busy", 320'(perm_busy_o), 320'd0);
        check("midrst_en", 320'(ascon_en_o), 320'd0);
        check("midrst_idx", 320'(round_idx_o), 320'd0);
        check("midrst_done", 320'(perm_done_o), 320'd0);
        rst_ni = 1'b1;
        tick();
        check("postrst_done", 320'(perm_done_o), 320'd0);
        check("postrst_busy", 320'(perm_busy_o), 320'd0);
        tick();
        tick();

        check("idx_queue_drained", 320'(q_idx.size()), 320'd0);
        check("done_queue_drained", 320'(q_done.size()), 320'd0);
        check("err_queue_drained", 320'(q_err.size()), 320'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
